// File: rtl/osc_pkg.sv
// Shared types and default timing constants for the oscillator measurement scheduler.
package osc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        GATE  = 3'd2,
        LATCH = 3'd3,
        SEND  = 3'd4
    } state_t;

    localparam int unsigned REF_CLK_DEF     = 10_000_000;
    localparam int unsigned STP_SMPL_DEF    = 600;
    localparam int unsigned ACK_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/osc_meas_sched_if.sv
// Control bus between the scheduler FSM (master) and its shared window/timeout counter (slave).
interface osc_meas_sched_if;

    logic        load;
    logic        en;
    logic [31:0] limit;
    logic        tc;

    modport master (output load, output en, output limit, input tc);
    modport slave  (input load, input en, input limit, output tc);

endinterface

// File: rtl/osc_sched_timer.sv
// 32-bit counter, cleared by load, advanced by en; tc flags count == limit.
module osc_sched_timer (
    input  logic               clk,
    input  logic               rst,
    osc_meas_sched_if.slave    tmr
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: load clears, enable increments, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (tmr.load) begin
            cnt_d = '0;
        end else if (tmr.en) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmr.tc = (cnt_q == tmr.limit);

endmodule

// File: rtl/osc_meas_sched.sv
// Measurement window scheduler: clear, gate, latch counters, then hand a frame to the UART.
module osc_meas_sched
    import osc_pkg::*;
#(
    parameter int unsigned REF_CLK     = REF_CLK_DEF,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned STP_SMPL    = STP_SMPL_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                              ref_clk_buf,
    input  logic                              rst,
    input  logic [NUM_CH-1:0]                 latch_ack_i,
    input  logic                              tx_busy_i,
    output logic                              osc_rst_o,
    output logic                              osc_halt_o,
    output logic                              latch_req_o,
    output logic                              sens_start_o,
    output logic                              tx_start_o,
    output logic                              frame_halt_o,
    output logic [NUM_CH-1:0]                 ch_err_o,
    output logic [$clog2(STP_SMPL+1)-1:0]     win_cnt_o
);

    localparam int unsigned WCW = $clog2(STP_SMPL + 1);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [NUM_CH-1:0] ch_err_q, ch_err_d;
    logic [WCW-1:0]    win_cnt_q, win_cnt_d;
    logic              frame_halt_q, frame_halt_d;

    logic [NUM_CH-1:0] ack_seen;
    logic              halt_win;

    osc_meas_sched_if tmr_bus ();

    // One counter serves both the gate window and the latch timeout: the two never overlap.
    osc_sched_timer u_timer (
        .clk (ref_clk_buf),
        .rst (rst),
        .tmr (tmr_bus)
    );

    assign halt_win = (win_cnt_q == '0);
    assign ack_seen = ack_q | latch_ack_i;

    // Next-state, strobes and timer control for the window sequence.
    always_comb begin
        state_d        = state_q;
        ack_d          = ack_q;
        ch_err_d       = ch_err_q;
        win_cnt_d      = win_cnt_q;
        frame_halt_d   = frame_halt_q;
        tmr_bus.load   = 1'b0;
        tmr_bus.en     = 1'b0;
        tmr_bus.limit  = '0;
        osc_rst_o      = 1'b0;
        sens_start_o   = 1'b0;
        latch_req_o    = 1'b0;
        tx_start_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = CLEAR;
            end
            CLEAR: begin
                osc_rst_o    = 1'b1;
                sens_start_o = 1'b1;
                tmr_bus.load = 1'b1;
                ack_d        = '0;
                state_d      = GATE;
            end
            GATE: begin
                tmr_bus.en    = 1'b1;
                tmr_bus.limit = 32'(REF_CLK - 1);
                if (tmr_bus.tc) begin
                    // Reclear so the latch timeout starts from zero on LATCH entry.
                    tmr_bus.load = 1'b1;
                    state_d      = halt_win ? SEND : LATCH;
                end
            end
            LATCH: begin
                latch_req_o   = 1'b1;
                tmr_bus.en    = 1'b1;
                tmr_bus.limit = 32'(ACK_TIMEOUT - 1);
                ack_d         = ack_seen;
                // Same-cycle ack completion takes precedence over the timeout.
                if ((&ack_seen) || tmr_bus.tc) begin
                    ch_err_d = ~ack_seen;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (!tx_busy_i) begin
                    tx_start_o   = 1'b1;
                    frame_halt_d = halt_win;
                    win_cnt_d    = (win_cnt_q == WCW'(STP_SMPL - 1)) ? '0 : win_cnt_q + WCW'(1);
                    state_d      = CLEAR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and window bookkeeping registers with asynchronous reset.
    always_ff @(posedge ref_clk_buf or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            ch_err_q     <= '0;
            win_cnt_q    <= '0;
            frame_halt_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            ch_err_q     <= ch_err_d;
            win_cnt_q    <= win_cnt_d;
            frame_halt_q <= frame_halt_d;
        end
    end

    assign osc_halt_o   = (state_q != IDLE) && halt_win;
    assign frame_halt_o = (state_q == SEND) ? halt_win : frame_halt_q;
    assign ch_err_o     = ch_err_q;
    assign win_cnt_o    = win_cnt_q;

endmodule
